// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
// Port 0 is the CPU memory path, port 1 the loader/debug path.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam int PORT_CPU  = 0;
   localparam int PORT_LOAD = 1;
   localparam int WAIT_DEF  = 2;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request ports,
// shared read data and per-port acknowledge.
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);

   logic [1:0]             req;
   logic [1:0]             we;
   logic [1:0][1:0]        be;
   logic [1:0][ADDR_W-1:0] addr;
   logic [1:0][DATA_W-1:0] wdata;
   logic [1:0]             ack;
   logic [DATA_W-1:0]      rdata;

   modport master (
      output req, we, be, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output ack, rdata
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins,
// on a tie the port that was not served last wins.
module rr_pick2
   import sram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       any,
   output logic       pick
);

   always_comb begin
      any  = |req;
      pick = 1'b0;
      unique case (1'b1)
         (req == 2'b11): pick = ~last;
         (req == 2'b10): pick = 1'b1;
         default:        pick = 1'b0;
      endcase
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between CPU and loader ports with fixed
// wait states; strobes are registered so they never glitch.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = WAIT_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   sram_arbiter_if.slave     bus,
   output logic              Mem_CE,
   output logic              Mem_UB,
   output logic              Mem_LB,
   output logic              Mem_OE,
   output logic              Mem_WE,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] Data_to_SRAM,
   output logic              Data_oe,
   input  logic [DATA_W-1:0] Data_from_SRAM
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t state, state_d;
   logic [3:0] cnt, cnt_d;
   logic gnt, gnt_d;
   logic last, last_d;
   logic wr, wr_d;
   logic any, pick;
   logic ce_d, ub_d, lb_d, oe_d, we_d, doe_d;
   logic [1:0] ack_q, ack_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wd_d, rd_q, rd_d;

   rr_pick2 u_pick (
      .req  (bus.req),
      .last (last),
      .any  (any),
      .pick (pick)
   );

   // Strobe values are computed for the coming state and registered.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      gnt_d   = gnt;
      last_d  = last;
      wr_d    = wr;
      ce_d    = 1'b1;
      ub_d    = 1'b1;
      lb_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      doe_d   = 1'b0;
      ack_d   = '0;
      addr_d  = ADDR;
      wd_d    = Data_to_SRAM;
      rd_d    = rd_q;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_d = ACCESS;
               cnt_d   = CNT_LOAD;
               gnt_d   = pick;
               last_d  = pick;
               wr_d    = bus.we[pick];
               addr_d  = bus.addr[pick];
               wd_d    = bus.wdata[pick];
               ce_d    = 1'b0;
               oe_d    = bus.we[pick];
               we_d    = ~bus.we[pick];
               ub_d    = bus.we[pick] & ~bus.be[pick][1];
               lb_d    = bus.we[pick] & ~bus.be[pick][0];
               doe_d   = bus.we[pick];
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               state_d          = DONE;
               ack_d[PORT_CPU]  = ~gnt;
               ack_d[PORT_LOAD] = gnt;
               if (!wr) rd_d = Data_from_SRAM;
            end else begin
               cnt_d = cnt - 4'd1;
               ce_d  = 1'b0;
               oe_d  = wr;
               we_d  = ~wr;
               ub_d  = Mem_UB;
               lb_d  = Mem_LB;
               doe_d = wr;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state        <= IDLE;
         cnt          <= '0;
         gnt          <= 1'b0;
         last         <= 1'(PORT_LOAD);
         wr           <= 1'b0;
         Mem_CE       <= 1'b1;
         Mem_UB       <= 1'b1;
         Mem_LB       <= 1'b1;
         Mem_OE       <= 1'b1;
         Mem_WE       <= 1'b1;
         Data_oe      <= 1'b0;
         ADDR         <= '0;
         Data_to_SRAM <= '0;
         ack_q        <= '0;
         rd_q         <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         gnt          <= gnt_d;
         last         <= last_d;
         wr           <= wr_d;
         Mem_CE       <= ce_d;
         Mem_UB       <= ub_d;
         Mem_LB       <= lb_d;
         Mem_OE       <= oe_d;
         Mem_WE       <= we_d;
         Data_oe      <= doe_d;
         ADDR         <= addr_d;
         Data_to_SRAM <= wd_d;
         ack_q        <= ack_d;
         rd_q         <= rd_d;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.rdata = rd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vectors, corner sequences and
// random two-port traffic against a memory-level reference model.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int W  = 2;

   logic Clk, Reset;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_oe;
   logic [AW-1:0] ADDR;
   logic [DW-1:0] Data_to_SRAM, Data_from_SRAM;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   logic ce1, ub1, lb1, oe1, we1, doe1;
   logic [AW-1:0] a1;
   logic [DW-1:0] dts1, dfs1;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus),
      .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
      .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
      .Data_to_SRAM(Data_to_SRAM), .Data_oe(Data_oe),
      .Data_from_SRAM(Data_from_SRAM)
   );

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .bus(bus1),
      .Mem_CE(ce1), .Mem_UB(ub1), .Mem_LB(lb1),
      .Mem_OE(oe1), .Mem_WE(we1), .ADDR(a1),
      .Data_to_SRAM(dts1), .Data_oe(doe1),
      .Data_from_SRAM(dfs1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem  [0:65535];
   logic [15:0] gold [0:65535];
   logic        m_last;
   logic [15:0] m_rdata;
   logic [15:0] got_rd;

   logic [1:0]        c_we;
   logic [1:0][1:0]   c_be;
   logic [1:0][19:0]  c_addr;
   logic [1:0][15:0]  c_wd;

   typedef struct {
      logic        p;
      logic        w;
      logic [1:0]  be;
      logic [19:0] a;
      logic [15:0] d;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [15:0] dflt(input logic [19:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   function automatic logic [15:0] gmerge(input logic [15:0] o,
                                          input logic [15:0] d,
                                          input logic [1:0] be);
      return {be[1] ? d[15:8] : o[15:8], be[0] ? d[7:0] : o[7:0]};
   endfunction

   function automatic logic [15:0] smerge(input logic [15:0] o,
                                          input logic [15:0] d,
                                          input logic ub,
                                          input logic lb);
      return {ub ? o[15:8] : d[15:8], lb ? o[7:0] : d[7:0]};
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // SRAM pin model: byte writes on WE low, read data driven mid-cycle.
   always @(posedge Clk)
      if (Reset && !Mem_CE && !Mem_WE)
         mem[ADDR[15:0]] <= smerge(mem[ADDR[15:0]],
                                   Data_oe ? Data_to_SRAM : 16'hDEAD,
                                   Mem_UB, Mem_LB);

   always @(negedge Clk)
      Data_from_SRAM <= (!Mem_CE && !Mem_OE && Mem_WE) ?
                        mem[ADDR[15:0]] : 16'h0000;

   always @(negedge Clk)
      dfs1 <= (!ce1 && !oe1) ? (a1[15:0] ^ 16'h1111) : 16'h0000;

   task automatic run_round(input logic [1:0] mask);
      int ord [2];
      int lat [2];
      int n, cyc, lim, err, ap;
      bit act, dn;
      logic [1:0] done, ea;
      logic [5:0] es;
      logic [15:0] exp_rd;
      n = (mask == 2'b11) ? 2 : 1;
      if (mask == 2'b11) ord[0] = m_last ? 0 : 1;
      else ord[0] = mask[1] ? 1 : 0;
      ord[1] = 1 - ord[0];
      lat[0] = 0;
      lat[1] = 0;
      @(negedge Clk);
      for (int i = 0; i < 2; i++)
         if (mask[i]) begin
            bus.we[i]    = c_we[i];
            bus.be[i]    = c_be[i];
            bus.addr[i]  = c_addr[i];
            bus.wdata[i] = c_wd[i];
         end
      bus.req = mask;
      done = 2'b00;
      cyc  = 0;
      err  = 0;
      lim  = n * (W + 2) + 4;
      while (done != mask && cyc < lim) begin
         @(negedge Clk);
         cyc++;
         act = 0;
         dn  = 0;
         ap  = ord[0];
         for (int k = 0; k < n; k++) begin
            int s;
            s = 1 + k * (W + 2);
            if (cyc >= s && cyc < s + W) begin act = 1; ap = ord[k]; end
            if (cyc == s + W) begin dn = 1; ap = ord[k]; end
         end
         es = 6'b111110;
         ea = 2'b00;
         if (act)
            es = {1'b0,
                  c_we[ap] ? ~c_be[ap][1] : 1'b0,
                  c_we[ap] ? ~c_be[ap][0] : 1'b0,
                  c_we[ap], ~c_we[ap], c_we[ap]};
         if (dn) ea[ap] = 1'b1;
         if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_oe} !== es) err++;
         if (bus.ack !== ea) err++;
         if ((act || dn) && ADDR !== c_addr[ap]) err++;
         if (act && c_we[ap] && Data_to_SRAM !== c_wd[ap]) err++;
         for (int i = 0; i < 2; i++)
            if (bus.ack[i] && mask[i] && !done[i]) begin
               lat[i]     = cyc;
               done[i]    = 1'b1;
               bus.req[i] = 1'b0;
               m_last     = (i == 1);
               if (c_we[i]) begin
                  gold[c_addr[i][15:0]] = gmerge(gold[c_addr[i][15:0]],
                                                 c_wd[i], c_be[i]);
                  exp_rd = m_rdata;
               end else begin
                  exp_rd  = gold[c_addr[i][15:0]];
                  m_rdata = exp_rd;
               end
               got_rd = bus.rdata;
               chk("ack_rdata", 32'(bus.rdata), 32'(exp_rd));
            end
      end
      chk("ack_done", 32'(done), 32'(mask));
      chk("ack_latency", lat[ord[0]], W + 1);
      if (n == 2) chk("ack_latency2", lat[ord[1]], 2 * W + 3);
      chk("strobe_seq", err, 0);
   endtask

   initial begin
      int cyc, na, bad, got, lowc;
      int t_a [4];
      int seq [4];

      for (int i = 0; i < 65536; i++) begin
         mem[i]  <= dflt(20'(i));
         gold[i]  = dflt(20'(i));
      end
      mem[16'h0123]  <= 16'hBEEF;
      gold[16'h0123]  = 16'hBEEF;

      tbl[0] = '{1'b0, 1'b0, 2'b00, 20'h00123, 16'h0000, 16'hBEEF};
      tbl[1] = '{1'b1, 1'b1, 2'b01, 20'h0FFFF, 16'h1234, 16'hBEEF};
      tbl[2] = '{1'b1, 1'b0, 2'b00, 20'h0FFFF, 16'h0000, 16'h5A34};
      tbl[3] = '{1'b0, 1'b1, 2'b00, 20'h00200, 16'hABCD, 16'h5A34};
      tbl[4] = '{1'b0, 1'b0, 2'b00, 20'h00200, 16'h0000, 16'hA7A5};
      tbl[5] = '{1'b0, 1'b1, 2'b11, 20'h00300, 16'h9876, 16'hA7A5};
      tbl[6] = '{1'b1, 1'b0, 2'b00, 20'h00300, 16'h0000, 16'h9876};
      tbl[7] = '{1'b1, 1'b1, 2'b10, 20'h00300, 16'h11FF, 16'h9876};
      tbl[8] = '{1'b0, 1'b0, 2'b00, 20'h00300, 16'h0000, 16'h1176};

      Reset = 1'b0;
      bus.req = '0;  bus.we = '0;  bus.be = '0;
      bus.addr = '0; bus.wdata = '0;
      bus1.req = '0; bus1.we = '0; bus1.be = '0;
      bus1.addr = '0; bus1.wdata = '0;
      m_last  = 1'b1;
      m_rdata = 16'h0;
      for (int i = 0; i < 4; i++) begin t_a[i] = 0; seq[i] = 0; end

      repeat (2) @(negedge Clk);
      chk("rst_strobes",
          32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_oe}),
          32'h3E);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_addr", 32'(ADDR), 0);
      chk("rst_wdata", 32'(Data_to_SRAM), 0);
      Reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         c_we[tbl[i].p]   = tbl[i].w;
         c_be[tbl[i].p]   = tbl[i].be;
         c_addr[tbl[i].p] = tbl[i].a;
         c_wd[tbl[i].p]   = tbl[i].d;
         run_round(tbl[i].p ? 2'b10 : 2'b01);
         chk("vec_rdata", 32'(got_rd), 32'(tbl[i].rd));
      end

      // Port 0 back-to-back: req stays high, address moves at the ack.
      @(negedge Clk);
      bus.we[0]   = 1'b0;
      bus.addr[0] = 20'h00010;
      bus.req     = 2'b01;
      cyc = 0; na = 0; bad = 0;
      while (na < 2 && cyc < 30) begin
         @(negedge Clk);
         cyc++;
         if (bus.ack[1]) bad++;
         if (bus.ack[0]) begin
            t_a[na] = cyc;
            chk(na == 0 ? "b2b_rd0" : "b2b_rd1", 32'(bus.rdata),
                32'(gold[16'h0010 + 16'(na)]));
            na++;
            bus.addr[0] = 20'h00011;
            if (na == 2) bus.req = 2'b00;
         end
      end
      chk("b2b_count", na, 2);
      chk("b2b_first", t_a[0], W + 1);
      chk("b2b_spacing", t_a[1] - t_a[0], W + 2);
      chk("b2b_port1_quiet", bad, 0);
      m_last  = 1'b0;
      m_rdata = gold[16'h0011];

      // Both ports requesting from reset onward.
      @(negedge Clk);
      Reset       = 1'b0;
      bus.we      = 2'b00;
      bus.addr[0] = 20'h00020;
      bus.addr[1] = 20'h00021;
      bus.req     = 2'b11;
      @(negedge Clk);
      chk("rst2_rdata", 32'(bus.rdata), 0);
      Reset = 1'b1;
      cyc = 0; na = 0; bad = 0;
      while (na < 4 && cyc < 40) begin
         @(negedge Clk);
         cyc++;
         if (bus.ack == 2'b11) bad++;
         for (int i = 0; i < 2; i++)
            if (bus.ack[i] && na < 4) begin
               seq[na] = i;
               t_a[na] = cyc;
               chk("rr_rdata", 32'(bus.rdata),
                   32'(gold[16'h0020 + 16'(i)]));
               na++;
            end
         if (na == 4) bus.req = 2'b00;
      end
      chk("rr_count", na, 4);
      chk("rr_order", 32'({seq[0][0], seq[1][0], seq[2][0], seq[3][0]}),
          32'b0101);
      chk("rr_first", t_a[0], W + 1);
      chk("rr_spacing", (t_a[1] - t_a[0] == W + 2) &&
                        (t_a[2] - t_a[1] == W + 2) &&
                        (t_a[3] - t_a[2] == W + 2), 1);
      chk("rr_exclusive", bad, 0);
      m_last  = 1'b1;
      m_rdata = gold[16'h0021];

      // Reset during the first access cycle of a port 1 write.
      @(negedge Clk);
      bus.we[1]    = 1'b1;
      bus.be[1]    = 2'b11;
      bus.addr[1]  = 20'h00040;
      bus.wdata[1] = 16'hDEAD;
      bus.req      = 2'b10;
      @(negedge Clk);
      chk("mid_active", 32'({Mem_CE, Mem_WE}), 0);
      #2 Reset = 1'b0;
      #1;
      chk("mid_strobes", 32'({Mem_CE, Mem_WE, Mem_OE, Data_oe}), 32'hE);
      chk("mid_ack", 32'(bus.ack), 0);
      @(negedge Clk);
      chk("mid_rdata", 32'(bus.rdata), 0);
      chk("mid_no_write", 32'(mem[16'h0040]), 32'(gold[16'h0040]));
      m_last  = 1'b1;
      m_rdata = 16'h0;
      Reset   = 1'b1;
      cyc = 0; got = 0;
      while (got == 0 && cyc < 20) begin
         @(negedge Clk);
         cyc++;
         if (bus.ack != 2'b00) begin
            got = 1;
            chk("mid_ack_port", 32'(bus.ack), 32'b10);
            chk("mid_ack_lat", cyc, W + 1);
            bus.req = 2'b00;
         end
      end
      chk("mid_got_ack", got, 1);
      gold[16'h0040] = 16'hDEAD;

      c_we[0]   = 1'b0;
      c_be[0]   = 2'b00;
      c_addr[0] = 20'h00040;
      c_wd[0]   = 16'h0;
      run_round(2'b01);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 2; i++) begin
            c_we[i]   = 1'($urandom_range(0, 1));
            c_be[i]   = 2'($urandom_range(0, 3));
            c_addr[i] = 20'(16'h0040 + 16'($urandom_range(0, 31)));
            c_wd[i]   = 16'($urandom);
         end
         run_round(2'($urandom_range(1, 3)));
      end

      // Single-wait-state instance.
      @(negedge Clk);
      bus1.we[0]   = 1'b0;
      bus1.addr[0] = 20'h00055;
      bus1.req     = 2'b01;
      cyc = 0; got = 0; lowc = 0;
      while (got == 0 && cyc < 10) begin
         @(negedge Clk);
         cyc++;
         if (!ce1) lowc++;
         if (bus1.ack[0]) begin
            got = 1;
            chk("w1_latency", cyc, 2);
            chk("w1_rdata", 32'(bus1.rdata), 32'h1144);
            bus1.req = 2'b00;
         end
      end
      chk("w1_got_ack", got, 1);
      chk("w1_ce_cycles", lowc, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single asynchronous 16-bit SRAM between two requesters: port 0 is the SLC-3 CPU memory path (MAR/MDR), port 1 is the loader/debug path (switch-driven program load and memory inspection).
- Sequences each SRAM access with fixed wait states and drives the active-low chip strobes (CE/UB/LB/OE/WE).
- Arbitrates requesters round-robin and returns read data with a one-cycle acknowledge.
- Sits between the CPU/loader and the SRAM pins; it replaces direct strobe generation by the control unit.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, number of cycles strobes are held active per access (legal range 1..15).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- req  in  2  per-port request, bit i = port i; held high until acked.
- we  in  2  per-port write enable (1 = write, 0 = read).
- be  in  2x2  per-port byte enables for writes, [1] = upper byte, [0] = lower byte.
- addr  in  2xADDR_W  per-port address.
- wdata  in  2xDATA_W  per-port write data.
- ack  out  2  per-port one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while the ack bit is high.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
- ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  write data toward the pins.
- Data_oe  out  1  high = drive Data_to_SRAM onto the pins.
- Data_from_SRAM  in  DATA_W  pin data for reads.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, all Mem_* = 1, Data_oe=0, ack=0, rdata=0, ADDR=0, Data_to_SRAM=0.
  - Round-robin pointer last=1, so port 0 wins the first tie.
- Reset mid-access: strobes go inactive immediately; the transaction is dropped and no ack is issued.
- States are IDLE, ACCESS and DONE. All outputs are registered.
- IDLE:
  - If req != 0, grant as follows: a single requester wins; if both request, the port != last wins.
  - Latch grant, addr, wdata, we and be into internal registers; update last to the granted port.
  - Load cnt=WAIT_CYCLES-1 and go to ACCESS.
  - If req == 0, stay in IDLE.
- ACCESS:
  - Mem_CE=0 and ADDR=latched address.
  - Read: Mem_OE=0, Mem_WE=1, Mem_UB=Mem_LB=0, Data_oe=0.
  - Write: Mem_OE=1, Mem_WE=0, Mem_UB=~be[1], Mem_LB=~be[0], Data_oe=1, Data_to_SRAM=latched wdata.
  - cnt decrements each cycle. When cnt==0, a read captures Data_from_SRAM into rdata, and the state moves to DONE.
- DONE:
  - All strobes return to 1 and Data_oe=0. ADDR holds for address hold time.
  - ack[grant]=1 for exactly this cycle; rdata holds the captured value (write: rdata unchanged).
  - Next state is IDLE.
- Latency: a request sampled in IDLE at cycle t gets ack at cycle t+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- Handshake:
  - The transfer completes at the clock edge where req[i]&ack[i].
  - The requester may change req/addr at that edge; a req still high in the following IDLE is a new request (back-to-back allowed).
  - Requester inputs must be stable from req rise to ack; the arbiter ignores changes after latching.
- ack is never asserted to both ports, and never to a port whose req was low at grant.
- Write strobe: WE never falls in the same cycle ADDR changes; WE rises one cycle before the next ADDR update (DONE cycle).
- be=00 on a write still runs the cycle, with UB=LB=1 (no bytes written), and is acked normally.

Decomposition:
- Package sram_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}.
  - Port index constants PORT_CPU=0, PORT_LOAD=1.
  - Default WAIT_CYCLES.
- Sub-module rr_pick2: combinational 2-way round-robin grant from req and last. Pointer storage stays in sram_arbiter.

Test Plan:
- Port 0 read, addr=0x00123, SRAM model returns 0xBEEF, WAIT_CYCLES=2 → CE=OE=0 for 2 cycles, ack[0] pulses at t+3, rdata=0xBEEF, Data_oe=0 throughout.
- Port 1 write, addr=0x0FFFF, wdata=0x1234, be=01 → WE=0 and LB=0/UB=1 for 2 cycles, Data_oe=1, Data_to_SRAM=0x1234, WE high in DONE with ADDR unchanged, ack[1] at t+3.
- Both req high continuously from reset, each completing at ack then re-requesting → grant order 0,1,0,1; one access per 4 cycles; never both ack bits set.
- Port 0 back-to-back reads 0x10 then 0x11 (req kept high, addr updated at ack edge) → second access starts in the very next IDLE, ack spacing exactly 4 cycles.
- Reset asserted during the 1st ACCESS cycle of a write → Mem_WE/Mem_CE go high without a clock edge, no ack; after release, pending port 1 req wins (last=1 reset means port 0 first if both).
- WAIT_CYCLES=1 rebuild, single read → ack at t+2, rdata correct.
